// File: rtl/pwm_pkg.sv
// pwm_pkg: constants and types shared by the PWM capture block and its
// conditioner (and, for the period constant, by the PWM generator).
package pwm_pkg;

  // Default clock frequency in Hz and the nominal PWM period derived from it.
  localparam int unsigned CLK_FREQ_DEF      = 25_000_000;
  localparam int unsigned PWM_PERIOD_CYCLES = CLK_FREQ_DEF / 1250;

  // Default width of counters and measurement outputs.
  localparam int CNT_W_DEF = 16;

  // Capture FSM states.
  typedef logic [1:0] state_t;
  localparam state_t S_SYNC  = 2'd0;
  localparam state_t S_HIGH  = 2'd1;
  localparam state_t S_LOW   = 2'd2;
  localparam state_t S_STUCK = 2'd3;

  // Conditioned input: level is aligned with the rise/fall strobes, so in the
  // cycle a rise is flagged, level already reads 1.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } cond_t;

endpackage

// File: rtl/pwm_in_conditioner.sv
// pwm_in_conditioner: 2-FF synchronizer, optional consensus glitch filter
// (enabled by defining PWM_CAPTURE_FILTER_EN) and edge detector.
// The rise and fall paths share one pipeline, so both edges see identical
// latency and downstream cycle counts are exact.
module pwm_in_conditioner
  import pwm_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_pwm,
  output cond_t o_cond
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic       r_rise;
  logic       r_fall;
  logic [2:0] r_warm;
  logic       w_level;
  logic       w_armed;

`ifdef PWM_CAPTURE_FILTER_EN
  // One extra warm-up cycle so the filter output has been seeded before
  // the previous-level register copies it.
  localparam logic [2:0] WARM_DONE = 3'd4;
`else
  localparam logic [2:0] WARM_DONE = 3'd3;
`endif

  // Edges are only reported once the pipeline holds real pin samples; this
  // keeps a pin that is already high at reset release from looking like a rise.
  assign w_armed = (r_warm == WARM_DONE);

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
    end
  end

  // Warm-up counter after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warm <= 3'd0;
    end else if (!w_armed) begin
      r_warm <= r_warm + 3'd1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FC_W = $clog2(FILTER_LEN + 1);

  logic            r_filt;
  logic [FC_W-1:0] r_fcnt;

  // Consensus filter: output flips only after FILTER_LEN consecutive samples
  // that disagree with it; shorter pulses never reach the edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b0;
      r_fcnt <= '0;
    end else if (!w_armed) begin
      r_filt <= r_sync2;
      r_fcnt <= '0;
    end else if (r_sync2 != r_filt) begin
      if (r_fcnt == FC_W'(FILTER_LEN - 1)) begin
        r_filt <= r_sync2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end else begin
      r_fcnt <= '0;
    end
  end

  assign w_level = r_filt;
`else
  logic w_unused_filter_len;

  assign w_level             = r_sync2;
  assign w_unused_filter_len = (FILTER_LEN > 0);
`endif

  // Edge detect against the previous conditioned level; rise and fall are
  // mutually exclusive by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_level;
      r_rise <= w_armed &  w_level & ~r_prev;
      r_fall <= w_armed & ~w_level &  r_prev;
    end
  end

  // Packed in member order: level, rise, fall.
  assign o_cond = {r_prev, r_rise, r_fall};

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period (rise-to-rise) and high time (rise-to-fall) of
// an external PWM input in clk cycles, strobes meas_valid for one cycle per
// completed period and flags a stuck input after TIMEOUT edge-free cycles.
// Optional glitch filter: define PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TIMEOUT    = 65535,
  parameter int FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  cond_t            w_cond;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high_lat;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic             r_meas_valid;
  logic             r_stuck_level;
  logic             w_timeout;
  logic             w_cap_high;
  logic             w_cap_period;
  logic             w_enter_stuck;
  logic             w_stuck;
  logic             w_unused_clk_freq;

  // CLK_FREQ only documents the clock the counts refer to.
  assign w_unused_clk_freq = (CLK_FREQ != 0);

  pwm_in_conditioner #(
    .FILTER_LEN (FILTER_LEN)
  ) u_cond (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pwm  (pwm_in),
    .o_cond (w_cond)
  );

  assign w_timeout = (r_cnt == TIMEOUT_C);

  // Cycles since the last rise, saturating at TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_cond.rise) begin
      r_cnt <= CNT_W'(1);
    end else if (!w_timeout) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: edges win over the timeout in the same cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SYNC: begin
        if (w_cond.rise) begin
          w_state_next = S_HIGH;
        end else if (w_timeout && !w_cond.fall) begin
          w_state_next = S_STUCK;
        end
      end
      S_HIGH: begin
        if (w_cond.fall) begin
          w_state_next = S_LOW;
        end else if (w_timeout && !w_cond.rise) begin
          w_state_next = S_STUCK;
        end
      end
      S_LOW: begin
        if (w_cond.rise) begin
          w_state_next = S_HIGH;
        end else if (w_timeout && !w_cond.fall) begin
          w_state_next = S_STUCK;
        end
      end
      S_STUCK: begin
        if (w_cond.rise) begin
          w_state_next = S_HIGH;
        end
      end
      default: w_state_next = S_SYNC;
    endcase
  end

  // FSM outputs: capture enables and the stuck flag.
  always_comb begin
    w_cap_high    = (r_state == S_HIGH) && w_cond.fall;
    w_cap_period  = (r_state == S_LOW)  && w_cond.rise;
    w_enter_stuck = (r_state != S_STUCK) && (w_state_next == S_STUCK);
    w_stuck       = (r_state == S_STUCK);
  end

  // Measurement registers: high time is latched at the fall and published
  // together with the period at the closing rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high_lat    <= '0;
      r_period      <= '0;
      r_high_time   <= '0;
      r_meas_valid  <= 1'b0;
      r_stuck_level <= 1'b0;
    end else begin
      r_meas_valid  <= w_cap_period;
      r_stuck_level <= (w_state_next == S_STUCK) ? w_cond.level : 1'b0;
      if (w_cap_high) begin
        r_high_lat <= r_cnt;
      end
      if (w_cap_period) begin
        r_period    <= r_cnt;
        r_high_time <= r_high_lat;
      end else if (w_enter_stuck) begin
        r_period    <= '0;
        r_high_time <= '0;
      end
    end
  end

  assign period      = r_period;
  assign high_time   = r_high_time;
  assign meas_valid  = r_meas_valid;
  assign stuck       = w_stuck;
  assign stuck_level = r_stuck_level;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives PWM waveforms into pwm_capture; expected strobes are
// queued when the closing rise is driven and compared when meas_valid fires.
module tb_pwm_capture;

  localparam int CNT_W      = 16;
  localparam int TIMEOUT    = 1000;
  localparam int FILTER_LEN = 4;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;

  typedef struct {
    int period;
    int high;
  } exp_t;

  typedef struct {
    int high;
    int low;
    int exp_period;
    int exp_high;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   checks   = 0;
  int   failures = 0;
  bit   prev_valid;
  int   prev_h;
  int   prev_l;

  pwm_capture #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .FILTER_LEN (FILTER_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .period      (period),
    .high_time   (high_time),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) tick();
  endtask

  task automatic push_exp(input int p, input int h);
    exp_t e;
    e.period = p;
    e.high   = h;
    exp_q.push_back(e);
  endtask

  // A rise closes the previously driven period, if there was a complete one.
  task automatic start_period(input int h, input int l);
    if (prev_valid) push_exp(prev_h + prev_l, prev_h);
    prev_valid = 1'b1;
    prev_h     = h;
    prev_l     = l;
  endtask

  task automatic drive_period(input int h, input int l);
    start_period(h, l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_high_time"}, int'(high_time), 0);
    check({tag, "_meas_valid"}, int'(meas_valid), 0);
    check({tag, "_stuck"}, int'(stuck), 0);
    check({tag, "_stuck_level"}, int'(stuck_level), 0);
  endtask

  // Strobe monitor: one line per measurement, compared against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && meas_valid) begin
      check("strobe_while_stuck", int'(stuck), 0);
      check("strobe_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("strobe t=%0t period=%0d high_time=%0d (want %0d/%0d)",
                 $time, period, high_time, e.period, e.high);
        check("strobe_period", int'(period), e.period);
        check("strobe_high_time", int'(high_time), e.high);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{30, 70, 100, 30};
    vecs[1] = '{30, 70, 100, 30};
    vecs[2] = '{30, 70, 100, 30};
    vecs[3] = '{31, 69, 100, 31};
    vecs[4] = '{32, 68, 100, 32};
    vecs[5] = '{33, 67, 100, 33};
    prev_valid = 1'b0;
    prev_h     = 0;
    prev_l     = 0;

    // Reset state.
    repeat (4) tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (5) tick();

    // Steady and ramping high time; each rise closes the previous entry.
    for (int i = 0; i < 6; i++) begin
      if (i > 0) push_exp(vecs[i-1].exp_period, vecs[i-1].exp_high);
      hold(1'b1, vecs[i].high);
      hold(1'b0, vecs[i].low);
    end
    push_exp(vecs[5].exp_period, vecs[5].exp_high);

    // Final rise then held high: stuck after TIMEOUT cycles, no strobe.
    pwm_in = 1'b1;
    repeat (995) tick();
    check("pre_timeout_stuck", int'(stuck), 0);
    repeat (25) tick();
    check("timeout_stuck", int'(stuck), 1);
    check("timeout_stuck_level", int'(stuck_level), 1);
    check("timeout_period", int'(period), 0);
    check("timeout_high_time", int'(high_time), 0);
    wait_drain("drain_before_stuck");

    // Recover from stuck: first rise clears it without a strobe.
    hold(1'b0, 50);
    check("still_stuck_low", int'(stuck), 1);
    check("stuck_level_low", int'(stuck_level), 0);
    prev_valid = 1'b0;
    start_period(50, 150);
    hold(1'b1, 20);
    check("stuck_cleared", int'(stuck), 0);
    hold(1'b1, 30);
    hold(1'b0, 150);
    start_period(50, 150);
    hold(1'b1, 20);
    wait_drain("drain_200_50");

    // Asynchronous reset while high: outputs clear at once.
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    repeat (3) tick();
    rst_n      = 1'b1;
    prev_valid = 1'b0;
    hold(1'b1, 27);
    hold(1'b0, 70);
    drive_period(30, 70);
    drive_period(30, 70);

    // Two-cycle glitch in the low phase.
    start_period(30, 70);
    hold(1'b1, 30);
    hold(1'b0, 30);
`ifndef PWM_CAPTURE_FILTER_EN
    push_exp(60, 30);
`endif
    hold(1'b1, 2);
    hold(1'b0, 38);
`ifdef PWM_CAPTURE_FILTER_EN
    prev_h = 30;
    prev_l = 70;
`else
    prev_h = 2;
    prev_l = 38;
`endif
    drive_period(30, 70);
    start_period(30, 70);
    hold(1'b1, 20);
    wait_drain("drain_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
